// File: rtl/can_seq_pkg.sv
// ---------------------------------------------------------------------------
// can_seq_pkg
//  Shared definitions for the can_ctrl_sequencer block: sequencer states,
//  can_top_raw register addresses, command/mode constants and a helper that
//  clamps the requested TX byte count into the legal 1..13 range.
// ---------------------------------------------------------------------------
package can_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_RST,
        S_CFG_BTR,
        S_CFG_RUN,
        S_TX_LOAD,
        S_TX_CMD,
        S_TX_WAIT,
        S_TX_RD,
        S_TX_RD_WAIT,   // read strobe on the bus; data is returned next cycle
        S_TX_CHK,
        S_TX_REFUSE,
        S_FIN
    } seq_state_t;

    // can_top_raw register map (only the registers this block touches)
    localparam logic [7:0] ADDR_MODE   = 8'd0;
    localparam logic [7:0] ADDR_CMD    = 8'd1;
    localparam logic [7:0] ADDR_STATUS = 8'd2;
    localparam logic [7:0] ADDR_BTR0   = 8'd6;
    localparam logic [7:0] ADDR_BTR1   = 8'd7;
    localparam logic [7:0] ADDR_FDBTR0 = 8'd25;
    localparam logic [7:0] ADDR_FDBTR1 = 8'd26;

    localparam logic [7:0] CMD_TX         = 8'h01;
    localparam logic [7:0] MODE_RESET     = 8'h01;
    localparam int         STATUS_TCS_BIT = 3;
    localparam logic [7:0] STATUS_TCS_MSK = 8'(1 << STATUS_TCS_BIT);

    localparam int         TX_BUF_BYTES   = 13;

    // 0 is promoted to 1, anything above the buffer size is cut to 13
    function automatic logic [3:0] clamp_nbytes(input logic [3:0] n);
        if (n == 4'd0)
            return 4'd1;
        if (n > 4'd13)
            return 4'd13;
        return n;
    endfunction

endpackage

// File: rtl/can_seq_poll_timer.sv
// ---------------------------------------------------------------------------
// can_seq_poll_timer
//  Two counters used while waiting for a transmission to complete:
//   - gap counter: spaces status polls POLL_GAP cycles apart
//   - timeout counter: counts cycles since the transmit command, saturating
//     at POLL_TMO
// Ports
//  clk_i          in   clock
//  rst_i          in   synchronous reset, active-high
//  gap_clr_i      in   restart the gap counter
//  tmo_start_i    in   restart the timeout counter
//  gap_done_o     out  gap counter is in its last idle cycle
//  tmo_expired_o  out  timeout counter reached POLL_TMO
// ---------------------------------------------------------------------------
module can_seq_poll_timer #(
    parameter int POLL_GAP = 16,
    parameter int POLL_TMO = 200000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic gap_clr_i,
    input  logic tmo_start_i,
    output logic gap_done_o,
    output logic tmo_expired_o
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int TW = $clog2(POLL_TMO + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(POLL_TMO);

    logic [GW-1:0] r_gap;
    logic [TW-1:0] r_tmo;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gap <= '0;
            r_tmo <= '0;
        end else begin
            if (gap_clr_i)
                r_gap <= '0;
            else if (r_gap != GAP_LAST)
                r_gap <= r_gap + 1'b1;

            if (tmo_start_i)
                r_tmo <= '0;
            else if (r_tmo != TMO_MAX)
                r_tmo <= r_tmo + 1'b1;
        end
    end

    // the gap counter starts at 0 on entry, so GAP_LAST marks the POLL_GAP-th cycle
    assign gap_done_o    = (r_gap == GAP_LAST);
    assign tmo_expired_o = (r_tmo == TMO_MAX);

endmodule

// File: rtl/can_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// can_ctrl_sequencer
//  Drives the host register port and TX buffer port of one can_top_raw
//  instance. A configuration sequence (reset mode, bus timing, run mode) and
//  a transmit sequence (load buffer, command, poll status) share the port.
//  All outputs are registered: the FSM computes next-cycle output values.
// Ports
//  clk_i, rst_i                 clock, synchronous active-high reset
//  cfg_req_i / cfg_ack_o        config request / 1-cycle accept pulse
//  tx_req_i / tx_ack_o          transmit request / 1-cycle accept pulse
//  tx_frame_i, tx_nbytes_i      frame bytes (byte k -> TX addr k), byte count
//  busy_o, done_o, err_o        sequence active, end pulse, error with done
//  configured_o                 config completed since reset
//  reg_we_o, reg_re_o           register write / read strobes
//  reg_addr_w_o, reg_addr_r_o   register write / read addresses
//  reg_data_o, reg_data_i       register write data / read data
//  tx_we_o, tx_addr_o, tx_data_o  TX buffer write port
// ---------------------------------------------------------------------------
module can_ctrl_sequencer
    import can_seq_pkg::*;
#(
    parameter logic [7:0] BTR0     = 8'hC4,
    parameter logic [7:0] BTR1     = 8'h3E,
    parameter logic [7:0] FD_BTR0  = 8'hC4,
    parameter logic [7:0] FD_BTR1  = 8'h02,
    parameter logic [7:0] MODE_RUN = 8'h08,
    parameter int         POLL_GAP = 16,
    parameter int         POLL_TMO = 200000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cfg_req_i,
    output logic         cfg_ack_o,
    input  logic         tx_req_i,
    output logic         tx_ack_o,
    input  logic [103:0] tx_frame_i,
    input  logic [3:0]   tx_nbytes_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic         configured_o,
    output logic         reg_we_o,
    output logic         reg_re_o,
    output logic [7:0]   reg_addr_w_o,
    output logic [7:0]   reg_addr_r_o,
    output logic [7:0]   reg_data_o,
    input  logic [7:0]   reg_data_i,
    output logic         tx_we_o,
    output logic [3:0]   tx_addr_o,
    output logic [7:0]   tx_data_o
);

    seq_state_t    r_state, w_state_next;
    logic [3:0]    r_idx, w_idx_next;
    logic [103:0]  r_frame;
    logic [3:0]    r_nbytes;
    logic          r_err_pend, w_err_pend_next;
    logic          w_capture;

    logic          r_cfg_ack, r_tx_ack, r_busy, r_done, r_err, r_configured;
    logic          r_reg_we, r_reg_re, r_tx_we;
    logic [7:0]    r_addr_w, r_addr_r, r_wdata, r_tx_data;
    logic [3:0]    r_tx_addr;

    logic          w_cfg_ack, w_tx_ack, w_done, w_err, w_configured;
    logic          w_reg_we, w_reg_re, w_tx_we;
    logic [7:0]    w_addr_w, w_addr_r, w_wdata, w_tx_data;
    logic [3:0]    w_tx_addr;

    logic          w_gap_clr, w_tmo_start, w_gap_done, w_tmo_expired;
    logic          w_tcs;
    logic [7:0]    w_frame_bytes [16];
    logic [7:0]    w_btr_addr, w_btr_data;

    // Byte view of the captured frame; entries past the buffer read as zero
    // so every 4-bit index is in range.
    for (genvar gi = 0; gi < 16; gi++) begin : g_frame_bytes
        if (gi < TX_BUF_BYTES) begin : g_byte
            assign w_frame_bytes[gi] = r_frame[8*gi +: 8];
        end else begin : g_pad
            assign w_frame_bytes[gi] = 8'h00;
        end
    end

    // Masking keeps the whole status byte in the expression.
    assign w_tcs = |(reg_data_i & STATUS_TCS_MSK);

    always_comb begin
        w_btr_addr = ADDR_BTR0;
        w_btr_data = BTR0;
        case (r_idx[1:0])
            2'd1:    begin w_btr_addr = ADDR_BTR1;   w_btr_data = BTR1;    end
            2'd2:    begin w_btr_addr = ADDR_FDBTR0; w_btr_data = FD_BTR0; end
            2'd3:    begin w_btr_addr = ADDR_FDBTR1; w_btr_data = FD_BTR1; end
            default: begin w_btr_addr = ADDR_BTR0;   w_btr_data = BTR0;    end
        endcase
    end

    can_seq_poll_timer #(
        .POLL_GAP (POLL_GAP),
        .POLL_TMO (POLL_TMO)
    ) u_timer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .gap_clr_i     (w_gap_clr),
        .tmo_start_i   (w_tmo_start),
        .gap_done_o    (w_gap_done),
        .tmo_expired_o (w_tmo_expired)
    );

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_err_pend_next = r_err_pend;
        w_capture       = 1'b0;
        w_gap_clr       = 1'b0;
        w_tmo_start     = 1'b0;
        w_cfg_ack       = 1'b0;
        w_tx_ack        = 1'b0;
        w_done          = 1'b0;
        w_err           = 1'b0;
        w_configured    = r_configured;
        w_reg_we        = 1'b0;
        w_reg_re        = 1'b0;
        w_addr_w        = 8'h00;
        w_addr_r        = 8'h00;
        w_wdata         = 8'h00;
        w_tx_we         = 1'b0;
        w_tx_addr       = 4'h0;
        w_tx_data       = 8'h00;

        case (r_state)
            S_IDLE: begin
                w_err_pend_next = 1'b0;
                w_idx_next      = 4'd0;
                if (cfg_req_i) begin
                    w_cfg_ack    = 1'b1;
                    w_state_next = S_CFG_RST;
                end else if (tx_req_i) begin
                    w_tx_ack     = 1'b1;
                    w_capture    = 1'b1;
                    w_state_next = r_configured ? S_TX_LOAD : S_TX_REFUSE;
                end
            end
            S_CFG_RST: begin
                w_reg_we     = 1'b1;
                w_addr_w     = ADDR_MODE;
                w_wdata      = MODE_RESET;
                w_state_next = S_CFG_BTR;
            end
            S_CFG_BTR: begin
                w_reg_we   = 1'b1;
                w_addr_w   = w_btr_addr;
                w_wdata    = w_btr_data;
                w_idx_next = r_idx + 4'd1;
                if (r_idx == 4'd3)
                    w_state_next = S_CFG_RUN;
            end
            S_CFG_RUN: begin
                w_reg_we     = 1'b1;
                w_addr_w     = ADDR_MODE;
                w_wdata      = MODE_RUN;
                w_configured = 1'b1;
                w_state_next = S_FIN;
            end
            S_TX_LOAD: begin
                w_tx_we    = 1'b1;
                w_tx_addr  = r_idx;
                w_tx_data  = w_frame_bytes[r_idx];
                w_idx_next = r_idx + 4'd1;
                if (r_idx == r_nbytes - 4'd1)
                    w_state_next = S_TX_CMD;
            end
            S_TX_CMD: begin
                w_reg_we     = 1'b1;
                w_addr_w     = ADDR_CMD;
                w_wdata      = CMD_TX;
                w_tmo_start  = 1'b1;
                w_gap_clr    = 1'b1;
                w_state_next = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (w_gap_done)
                    w_state_next = S_TX_RD;
            end
            S_TX_RD: begin
                w_reg_re     = 1'b1;
                w_addr_r     = ADDR_STATUS;
                w_state_next = S_TX_RD_WAIT;
            end
            S_TX_RD_WAIT: begin
                w_state_next = S_TX_CHK;
            end
            S_TX_CHK: begin
                // completion wins over a timeout seen in the same poll
                if (w_tcs) begin
                    w_err_pend_next = 1'b0;
                    w_state_next    = S_FIN;
                end else if (w_tmo_expired) begin
                    w_err_pend_next = 1'b1;
                    w_state_next    = S_FIN;
                end else begin
                    w_gap_clr    = 1'b1;
                    w_state_next = S_TX_WAIT;
                end
            end
            S_TX_REFUSE: begin
                w_done       = 1'b1;
                w_err        = 1'b1;
                w_state_next = S_IDLE;
            end
            S_FIN: begin
                w_done       = 1'b1;
                w_err        = r_err_pend;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_idx        <= 4'd0;
            r_frame      <= '0;
            r_nbytes     <= 4'd1;
            r_err_pend   <= 1'b0;
            r_cfg_ack    <= 1'b0;
            r_tx_ack     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_configured <= 1'b0;
            r_reg_we     <= 1'b0;
            r_reg_re     <= 1'b0;
            r_addr_w     <= 8'h00;
            r_addr_r     <= 8'h00;
            r_wdata      <= 8'h00;
            r_tx_we      <= 1'b0;
            r_tx_addr    <= 4'h0;
            r_tx_data    <= 8'h00;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_err_pend   <= w_err_pend_next;
            if (w_capture) begin
                r_frame  <= tx_frame_i;
                r_nbytes <= clamp_nbytes(tx_nbytes_i);
            end
            r_cfg_ack    <= w_cfg_ack;
            r_tx_ack     <= w_tx_ack;
            // busy follows the state we are entering, so it falls with done
            r_busy       <= (w_state_next != S_IDLE);
            r_done       <= w_done;
            r_err        <= w_err;
            r_configured <= w_configured;
            r_reg_we     <= w_reg_we;
            r_reg_re     <= w_reg_re;
            r_addr_w     <= w_addr_w;
            r_addr_r     <= w_addr_r;
            r_wdata      <= w_wdata;
            r_tx_we      <= w_tx_we;
            r_tx_addr    <= w_tx_addr;
            r_tx_data    <= w_tx_data;
        end
    end

    assign cfg_ack_o    = r_cfg_ack;
    assign tx_ack_o     = r_tx_ack;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign configured_o = r_configured;
    assign reg_we_o     = r_reg_we;
    assign reg_re_o     = r_reg_re;
    assign reg_addr_w_o = r_addr_w;
    assign reg_addr_r_o = r_addr_r;
    assign reg_data_o   = r_wdata;
    assign tx_we_o      = r_tx_we;
    assign tx_addr_o    = r_tx_addr;
    assign tx_data_o    = r_tx_data;

endmodule
